layernorm_variance: RTL and testbench
=====================================

// Module: layernorm_variance
// PURPOSE
//  Streaming mean/variance stage for layer-norm. Accepts one N-element vector of signed
//  fixed-point activations, one element per cycle. Produces its mean and its population
//  variance. The variance feeds the downstream sqrt stage (out_valid -> sqrt input_ready).
//  The mean is held for the normalizer. Uses the same Q(IL).(FL) format as the sqrt stage.
// PARAMETERS
//  IL      4   integer bits of in/mean/out, sign bit included
//  FL      16  fractional bits
//  LOG2_N  6   log2 of vector length N; N = 2**LOG2_N; LOG2_N >= 1
// PORTS
//  clk           in   1      clock, rising edge
//  reset         in   1      asynchronous, active-high reset
//  in            in   IL+FL  signed element Q(IL).(FL)
//  in_valid      in   1      element present on in
//  in_ready      out  1      block can accept an element
//  mean          out  IL+FL  signed vector mean, Q(IL).(FL)
//  out           out  IL+FL  variance, Q(IL).(FL), always >= 0
//  out_valid     out  1      mean/out valid; drives sqrt input_ready
//  output_taken  in   1      consumer has taken mean/out
//  state         out  2      FSM state, for debug
//  done          out  1      1-cycle pulse on the cycle out_valid first rises
// BEHAVIOUR
//  Clock and reset:
//  - Single clock domain. Reset is asynchronous and active-high.
//  - Reset values: state=00, count=0, accumulators=0, mean=0, out=0, out_valid=0, done=0.
//  - Reset while in_ready=1, so in_ready is high out of reset.
//  FSM:
//  - IDLE(00): in_ready=1. An accepted element (in_valid&in_ready) is accumulated and
//    count becomes 1. FSM goes to ACCUM.
//  - ACCUM(01): in_ready=1. Each accepted element is accumulated and count increments.
//    When the N-th element is accepted, FSM goes to CALC. in_valid=0 stalls with no change.
//  - CALC(10): in_ready=0. Lasts exactly 2 cycles, tracked by a sub-counter.
//    - C1 registers mean = sum>>>LOG2_N and ex2 = sumsq>>LOG2_N.
//    - C2 registers out and mean, then FSM goes to HOLD.
//  - HOLD(11): in_ready=0, out_valid=1, mean and out stable.
//    - On output_taken=1, next state is IDLE. Accumulators and count clear; out and mean hold.
//  - output_taken outside HOLD is ignored. in_valid while in_ready=0 is ignored (not queued).
//  Arithmetic (W = IL+FL):
//  - sq = in*in: 2W-bit unsigned, Q(2IL).(2FL).
//  - sumsq: 2W+LOG2_N bits unsigned.
//  - sum: W+LOG2_N bits signed.
//  - mean = sum >>> LOG2_N: arithmetic shift, floor, truncated to W bits. Cannot overflow.
//  - ex2 = sumsq >> LOG2_N.
//  - m2 = mean*mean: 2W bits, Q(2IL).(2FL).
//  - d = ex2 - m2, signed. If d < 0, d is forced to 0 (floor rounding of mean).
//  - out = d >> FL (truncate), saturated to 2**(W-1)-1 when it exceeds that value.
//  Latency and throughput:
//  - Last element accepted at cycle t -> out_valid=1 at cycle t+3.
//  - Throughput: N+3 cycles per vector, plus consumer stall.
//  - Reset asserted mid-vector discards partial sums immediately (async). No partial
//    output is ever presented.
// TESTING
//  - LOG2_N=2; in = 0x10000 x4 -> mean=0x10000, out=0x00000, out_valid 3 cycles after the
//    4th element.
//  - LOG2_N=2; in = 1.0,2.0,3.0,4.0 (0x10000..0x40000) -> mean=0x28000 (2.5),
//    out=0x14000 (1.25).
//  - LOG2_N=2; in = -2,-2,+2,+2 (0xE0000,0xE0000,0x20000,0x20000) -> mean=0, out=0x40000.
//  - LOG2_N=2; in = 0x80000,0x7FFFF,0x80000,0x7FFFF -> out saturates to 0x7FFFF;
//    mean=0xFFFFF.
//  - Stall/reset:
//    - in_valid gaps inside ACCUM -> same result as the contiguous case.
//    - output_taken held low 10 cycles -> out, mean and out_valid stable; in_ready=0.
//    - reset after 2 elements -> state=00, out=0. A following clean vector gives the
//      correct result.
//  - Back-to-back: output_taken in HOLD -> IDLE next cycle with in_ready=1. A second vector
//    gives an independent result with no carry-over in the accumulators.

Source files
------------

// File: rtl/layernorm_variance.sv
// Streaming mean / population-variance stage for layer-norm.
// One signed Q(IL).(FL) element is accepted per cycle. After N = 2**LOG2_N elements,
// two calculation cycles produce the vector mean and its variance. The result is held
// until the consumer takes it. The variance feeds the downstream sqrt stage.
module layernorm_variance #(
   parameter int IL     = 4,
   parameter int FL     = 16,
   parameter int LOG2_N = 6
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [IL+FL-1:0]     in,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [IL+FL-1:0]     mean,
   output logic [IL+FL-1:0]     out,
   output logic                 out_valid,
   input  logic                 output_taken,
   output logic [1:0]           state,
   output logic                 done
);

   localparam int W  = IL + FL;
   localparam int W2 = 2 * W;
   localparam int SW = W + LOG2_N;
   localparam int QW = W2 + LOG2_N;

   // Count value at which the accepted element is the last one of the vector (N-1).
   localparam logic [LOG2_N:0] LAST_IDX   = {1'b0, {LOG2_N{1'b1}}};
   localparam logic [LOG2_N:0] COUNT_ONE  = {{LOG2_N{1'b0}}, 1'b1};
   localparam logic [W2-1:0]   OUT_MAX_2W = {{(W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic [W-1:0]    OUT_MAX_W  = {1'b0, {(W-1){1'b1}}};

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ACCUM = 2'b01,
      CALC  = 2'b10,
      HOLD  = 2'b11
   } state_t;

   state_t                 state_q;
   logic [LOG2_N:0]        count_q;
   logic signed [SW-1:0]   sum_q;
   logic [QW-1:0]          sumsq_q;
   logic                   calcPhase_q;
   logic signed [W-1:0]    mean_q;
   logic [W2-1:0]          ex2_q;
   logic [W-1:0]           out_q;
   logic                   outValid_q;
   logic                   done_q;
   logic                   inReady_q;

   logic signed [W-1:0]    inS;
   logic signed [W2-1:0]   sqS;
   logic [W2-1:0]          sqVal;
   logic signed [SW-1:0]   inExt;
   logic [QW-1:0]          sqExt;
   logic signed [SW-1:0]   sum_d;
   logic [QW-1:0]          sumsq_d;
   logic signed [W-1:0]    meanCalc;
   logic [W2-1:0]          ex2Calc;
   logic signed [W2-1:0]   m2;
   logic signed [W2:0]     diff;
   logic [W2-1:0]          dPos;
   logic [W2-1:0]          dShift;
   logic [W-1:0]           outCalc;

   // Datapath: element square, running sums, floored mean, E[x^2] and clamped/saturated variance
   always_comb begin
      inS      = signed'(in);
      sqS      = inS * inS;
      sqVal    = unsigned'(sqS);
      inExt    = {{LOG2_N{in[W-1]}}, in};
      sqExt    = {{LOG2_N{1'b0}}, sqVal};
      sum_d    = sum_q + inExt;
      sumsq_d  = sumsq_q + sqExt;
      meanCalc = W'(sum_q >>> LOG2_N);
      ex2Calc  = W2'(sumsq_q >> LOG2_N);
      m2       = mean_q * mean_q;
      diff     = $signed({1'b0, ex2_q}) - $signed({1'b0, m2});
      dPos     = diff[W2] ? '0 : diff[W2-1:0];
      dShift   = dPos >> FL;
      outCalc  = (dShift > OUT_MAX_2W) ? OUT_MAX_W : dShift[W-1:0];
   end

   // Control FSM with registered handshake, result and debug outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         count_q     <= '0;
         sum_q       <= '0;
         sumsq_q     <= '0;
         calcPhase_q <= 1'b0;
         mean_q      <= '0;
         ex2_q       <= '0;
         out_q       <= '0;
         outValid_q  <= 1'b0;
         done_q      <= 1'b0;
         inReady_q   <= 1'b1;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (in_valid && inReady_q) begin
                  sum_q   <= inExt;
                  sumsq_q <= sqExt;
                  count_q <= COUNT_ONE;
                  state_q <= ACCUM;
               end
            end
            ACCUM: begin
               if (in_valid && inReady_q) begin
                  sum_q   <= sum_d;
                  sumsq_q <= sumsq_d;
                  count_q <= count_q + COUNT_ONE;
                  if (count_q == LAST_IDX) begin
                     state_q     <= CALC;
                     inReady_q   <= 1'b0;
                     calcPhase_q <= 1'b0;
                  end
               end
            end
            CALC: begin
               if (!calcPhase_q) begin
                  mean_q      <= meanCalc;
                  ex2_q       <= ex2Calc;
                  calcPhase_q <= 1'b1;
               end else begin
                  out_q       <= outCalc;
                  mean_q      <= mean_q;
                  outValid_q  <= 1'b1;
                  done_q      <= 1'b1;
                  calcPhase_q <= 1'b0;
                  state_q     <= HOLD;
               end
            end
            HOLD: begin
               if (output_taken) begin
                  state_q    <= IDLE;
                  outValid_q <= 1'b0;
                  inReady_q  <= 1'b1;
                  sum_q      <= '0;
                  sumsq_q    <= '0;
                  count_q    <= '0;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = inReady_q;
   assign mean      = mean_q;
   assign out       = out_q;
   assign out_valid = outValid_q;
   assign state     = state_q;
   assign done      = done_q;

endmodule

// File: tb/tb_layernorm_variance.sv
// Scoreboard testbench for layernorm_variance with N = 4 (LOG2_N = 2).
// The driver pushes the reference result of each vector. A negedge monitor pops
// and compares it whenever out_valid rises. It also checks that the result stays
// stable while the consumer stalls.
module tb_layernorm_variance;

   localparam int IL     = 4;
   localparam int FL     = 16;
   localparam int LOG2_N = 2;
   localparam int N      = 4;
   localparam int W      = IL + FL;
   localparam longint OUT_MAX = (64'sd1 <<< (W - 1)) - 1;

   typedef logic [W-1:0] vec_t [N];

   typedef struct {
      logic [W-1:0] meanV;
      logic [W-1:0] outV;
      int           cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [W-1:0]  dataIn;
   logic          inValid;
   logic          inReady;
   logic [W-1:0]  meanOut;
   logic [W-1:0]  varOut;
   logic          outValid;
   logic          outputTaken;
   logic [1:0]    stateOut;
   logic          doneOut;

   int   tests    = 0;
   int   failures = 0;
   int   cycleCnt = 0;
   exp_t sbQ[$];

   layernorm_variance #(.IL(IL), .FL(FL), .LOG2_N(LOG2_N)) dut (
      .clk          (clk),
      .reset        (reset),
      .in           (dataIn),
      .in_valid     (inValid),
      .in_ready     (inReady),
      .mean         (meanOut),
      .out          (varOut),
      .out_valid    (outValid),
      .output_taken (outputTaken),
      .state        (stateOut),
      .done         (doneOut)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Cycle counter used to check output latency
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Global watchdog so the run always terminates
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      tests++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
      end
   endtask

   // Reference model: floored mean, E[x^2] - mean^2 clamped at 0, then truncated and saturated
   task automatic refModel(input vec_t v, output logic [W-1:0] m, output logic [W-1:0] o);
      longint s   = 0;
      longint sq  = 0;
      longint x;
      longint mm;
      longint ex2;
      longint d;
      longint r;
      for (int i = 0; i < N; i++) begin
         x  = longint'(signed'(v[i]));
         s  += x;
         sq += x * x;
      end
      mm = s / N;
      if ((s % N) != 0 && s < 0) mm = mm - 1;
      ex2 = sq / N;
      d   = ex2 - mm * mm;
      if (d < 0) d = 0;
      r = d / (64'sd1 <<< FL);
      if (r > OUT_MAX) r = OUT_MAX;
      m = mm[W-1:0];
      o = r[W-1:0];
   endtask

   // Drive one vector, push its expected result, then stall and release the consumer side
   task automatic applyStimulus(input vec_t v, input int gapMax, input int takeDelay);
      exp_t e;
      int   acceptCycle;
      for (int i = 0; i < N; i++) begin
         if (gapMax > 0) begin
            int g = $urandom_range(0, gapMax);
            inValid = 1'b0;
            dataIn  = W'($urandom);
            repeat (g) begin
               @(posedge clk);
               #1;
            end
         end
         dataIn  = v[i];
         inValid = 1'b1;
         @(posedge clk);
         #1;
      end
      acceptCycle = cycleCnt;
      inValid     = 1'b0;
      refModel(v, e.meanV, e.outV);
      e.cyc = acceptCycle + 2;
      sbQ.push_back(e);
      for (int k = 0; k < 10 && !outValid; k++) begin
         @(posedge clk);
         #1;
      end
      if (!outValid) begin
         tests++;
         failures++;
         $display("[TB] FAIL out_valid_timeout: actual=0 required=1");
      end
      // Inputs offered while the block is busy must be ignored
      inValid = 1'b1;
      dataIn  = W'($urandom);
      repeat (takeDelay) begin
         @(posedge clk);
         #1;
      end
      outputTaken = 1'b1;
      @(posedge clk);
      #1;
      outputTaken = 1'b0;
      inValid     = 1'b0;
      checkOutput("idle_state_after_take", stateOut, 2'b00);
      checkOutput("in_ready_after_take", inReady, 1);
      checkOutput("out_valid_after_take", outValid, 0);
   endtask

   // Monitor: compare each presented result with the scoreboard and check hold stability
   initial begin
      logic prevValid = 1'b0;
      exp_t cur;
      forever begin
         @(negedge clk);
         if (reset) begin
            prevValid = 1'b0;
         end else begin
            if (outValid && !prevValid) begin
               if (sbQ.size() == 0) begin
                  tests++;
                  failures++;
                  $display("[TB] FAIL unexpected_output: actual=out_valid required=no_output");
               end else begin
                  cur = sbQ.pop_front();
                  checkOutput("mean", meanOut, cur.meanV);
                  checkOutput("variance", varOut, cur.outV);
                  checkOutput("done_pulse", doneOut, 1);
                  checkOutput("latency_cycle", cycleCnt, cur.cyc);
               end
            end else if (outValid) begin
               checkOutput("hold_mean", meanOut, cur.meanV);
               checkOutput("hold_variance", varOut, cur.outV);
               checkOutput("hold_in_ready", inReady, 0);
               checkOutput("hold_done", doneOut, 0);
            end
            prevValid = outValid;
         end
      end
   end

   // Main stimulus sequence
   initial begin
      vec_t v;
      reset       = 1'b1;
      dataIn      = '0;
      inValid     = 1'b0;
      outputTaken = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_state", stateOut, 2'b00);
      checkOutput("reset_in_ready", inReady, 1);
      checkOutput("reset_out_valid", outValid, 0);
      checkOutput("reset_mean", meanOut, 0);
      checkOutput("reset_out", varOut, 0);
      checkOutput("reset_done", doneOut, 0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      v = '{20'h10000, 20'h10000, 20'h10000, 20'h10000};
      applyStimulus(v, 0, 0);
      v = '{20'h10000, 20'h20000, 20'h30000, 20'h40000};
      applyStimulus(v, 0, 1);
      v = '{20'hE0000, 20'hE0000, 20'h20000, 20'h20000};
      applyStimulus(v, 0, 10);
      v = '{20'h80000, 20'h7FFFF, 20'h80000, 20'h7FFFF};
      applyStimulus(v, 0, 2);
      v = '{20'h10000, 20'h20000, 20'h30000, 20'h40000};
      applyStimulus(v, 3, 0);
      v = '{20'hFFFFF, 20'h00000, 20'h00000, 20'h00000};
      applyStimulus(v, 0, 0);

      // Reset in the middle of a vector discards the partial sums
      dataIn  = 20'h30000;
      inValid = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      inValid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      checkOutput("midreset_state", stateOut, 2'b00);
      checkOutput("midreset_out", varOut, 0);
      checkOutput("midreset_mean", meanOut, 0);
      checkOutput("midreset_out_valid", outValid, 0);
      checkOutput("midreset_in_ready", inReady, 1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      v = '{20'h10000, 20'h20000, 20'h30000, 20'h40000};
      applyStimulus(v, 0, 0);

      for (int r = 0; r < 14; r++) begin
         for (int i = 0; i < N; i++) begin
            if (r % 2 == 0) v[i] = W'($urandom);
            else            v[i] = W'($urandom_range(0, 20'h80000) - 20'h40000);
         end
         applyStimulus(v, $urandom_range(0, 2), $urandom_range(0, 3));
      end

      repeat (5) @(posedge clk);
      #1;
      checkOutput("scoreboard_drained", sbQ.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
